// File: rtl/mat_pkg.sv
// mat_pkg: shared opcode and FSM state enums plus instruction field positions for mat_core
package mat_pkg;
  typedef enum logic [3:0] {
    OP_HALT  = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_SEND  = 4'd3,
    OP_RECV  = 4'd4,
    OP_VADD  = 4'd5,
    OP_VMUL  = 4'd6
  } opcode_e;
  typedef enum logic [1:0] {RUN, SEND_WAIT, RECV_WAIT, HALTED} state_e;
  localparam int OP_LSB   = 28;
  localparam int CORE_LSB = 24;
  localparam int ADDR_LSB = 0;
endpackage

// File: rtl/mat_core_mem.sv
// mat_core_mem: unreset instruction (32-bit) and data (shortreal, wrapping vector port) memories, preloaded hierarchically
module mat_inst_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] inst_mem [DEPTH];
  always_ff @(posedge clock) if (we) inst_mem[waddr] <= wdata;
  assign rdata = inst_mem[raddr];
endmodule

module mat_data_mem #(
  parameter int DEPTH = 256,
  parameter int W     = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  shortreal                 wdata [W],
  output shortreal                 rdata [W]
);
  localparam int AW = $clog2(DEPTH);
  shortreal data_mem [DEPTH];
  always_ff @(posedge clock) if (we) for (int i = 0; i < W; i++) data_mem[addr + AW'(i)] <= wdata[i];
  always_comb for (int i = 0; i < W; i++) rdata[i] = data_mem[addr + AW'(i)];
endmodule

// File: rtl/mat_core.sv
// mat_core: vector core (LOAD/STORE/SEND/RECV/VADD/VMUL/HALT) on a switch; clock, active-low sync reset, done, send/recv handshakes; MAT_CORE_VMUL_EN enables VMUL (else opcode 6 is NOP)
module mat_core
  import mat_pkg::*;
#(
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             done,
  output logic                             switch_send_ready,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
  output shortreal                         switch_send_data [SWITCH_WIDTH],
  input  logic                             switch_send_ok,
  output logic                             switch_recv_request,
  output logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx,
  input  logic                             switch_recv_ready,
  input  shortreal                         switch_recv_data [SWITCH_WIDTH]
);
  localparam int DATA_MEM_SIZE = 256;
  localparam int INST_MEM_SIZE = 256;
  localparam int AW = $clog2(DATA_MEM_SIZE);
  localparam int PW = $clog2(INST_MEM_SIZE);
`ifdef MAT_CORE_VMUL_EN
  localparam bit VMUL_EN = 1'b1;
`else
  localparam bit VMUL_EN = 1'b0;
`endif
  state_e                           state;
  logic [PW-1:0]                    pc;
  logic [31:0]                      instr;
  logic [3:0]                       op;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] core;
  logic [AW-1:0]                    addr;
  logic                             store_en;
  logic                             unused_instr;
  shortreal                         vbuf [SWITCH_WIDTH];
  shortreal                         mem_rd [SWITCH_WIDTH];
  assign op           = instr[OP_LSB +: 4];
  assign core         = instr[CORE_LSB +: SWITCH_CORE_ADDR_SIZE];
  assign addr         = instr[ADDR_LSB +: AW];
  assign unused_instr = ^instr;
  assign store_en     = reset && state == RUN && op == OP_STORE;
  mat_inst_mem #(.DEPTH(INST_MEM_SIZE)) inst_mem (
    .clock(clock), .we(1'b0), .waddr('0), .wdata('0), .raddr(pc), .rdata(instr)
  );
  mat_data_mem #(.DEPTH(DATA_MEM_SIZE), .W(SWITCH_WIDTH)) data_mem (
    .clock(clock), .we(store_en), .addr(addr), .wdata(vbuf), .rdata(mem_rd)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                <= RUN;
      pc                   <= '0;
      done                 <= 1'b0;
      switch_send_ready    <= 1'b0;
      switch_recv_request  <= 1'b0;
      switch_send_core_idx <= '0;
      switch_recv_core_idx <= '0;
      for (int i = 0; i < SWITCH_WIDTH; i++) begin
        vbuf[i]             <= 0.0;
        switch_send_data[i] <= 0.0;
      end
    end else begin
      case (state)
        RUN: begin
          case (op)
            OP_HALT: begin
              state <= HALTED;
              done  <= 1'b1;
            end
            OP_SEND: begin
              state                <= SEND_WAIT;
              switch_send_ready    <= 1'b1;
              switch_send_core_idx <= core;
              for (int i = 0; i < SWITCH_WIDTH; i++) switch_send_data[i] <= vbuf[i];
            end
            OP_RECV: begin
              state                <= RECV_WAIT;
              switch_recv_request  <= 1'b1;
              switch_recv_core_idx <= core;
            end
            default: pc <= pc + 1'b1;
          endcase
          for (int i = 0; i < SWITCH_WIDTH; i++)
            vbuf[i] <= op == OP_LOAD ? mem_rd[i] :
                       op == OP_VADD ? vbuf[i] + mem_rd[i] :
                       (op == OP_VMUL && VMUL_EN) ? vbuf[i] * mem_rd[i] : vbuf[i];
        end
        SEND_WAIT: if (switch_send_ok) begin
          state                <= RUN;
          pc                   <= pc + 1'b1;
          switch_send_ready    <= 1'b0;
          switch_send_core_idx <= '0;
          for (int i = 0; i < SWITCH_WIDTH; i++) switch_send_data[i] <= 0.0;
        end
        RECV_WAIT: if (switch_recv_ready) begin
          state                <= RUN;
          pc                   <= pc + 1'b1;
          switch_recv_request  <= 1'b0;
          switch_recv_core_idx <= '0;
          for (int i = 0; i < SWITCH_WIDTH; i++) vbuf[i] <= switch_recv_data[i];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_core.sv
// tb_mat_core: randomized scoreboard bench for mat_core against a program-level interpreter model
module tb_mat_core;
  localparam int N = 4, W = 16, CAW = 2, MS = 256;
  logic clock = 1'b0, reset = 1'b0, done, send_ready, send_ok = 1'b0, recv_request, recv_ready = 1'b0;
  logic [CAW-1:0] send_idx, recv_idx;
  shortreal send_data [W];
  shortreal recv_data [W];
  int n_checks = 0, n_fail = 0, edges = 0;
  logic [31:0] prog [MS];
  shortreal mem0 [MS];
  shortreal exp_mem [MS];
  int send_core_q[$], send_dly_q[$], send_len_q[$], recv_core_q[$], recv_dly_q[$], done_q[$];
  shortreal send_data_q[$], recv_vec_q[$];
  bit done_checked = 0;
  int s_fix = -1, r_fix = -1;
  shortreal recv_fix = -1.0;

  mat_core #(.SWITCH_CORE_SIZE(N), .SWITCH_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .done(done),
    .switch_send_ready(send_ready), .switch_send_core_idx(send_idx), .switch_send_data(send_data),
    .switch_send_ok(send_ok),
    .switch_recv_request(recv_request), .switch_recv_core_idx(recv_idx),
    .switch_recv_ready(recv_ready), .switch_recv_data(recv_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edges <= reset ? edges + 1 : 0;

  task automatic check(input string name, input bit ok, input string got, input string exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int core, input int a);
    return {4'(op), 4'(core), 8'h00, 16'(a)};
  endfunction

  task automatic mem_check(input string name);
    int bad;
    bad = -1;
    for (int i = MS - 1; i >= 0; i--) if (dut.data_mem.data_mem[i] != exp_mem[i]) bad = i;
    check(name, bad < 0,
          bad < 0 ? "match" : $sformatf("mem[%0d]=%f", bad, dut.data_mem.data_mem[bad]),
          bad < 0 ? "match" : $sformatf("mem[%0d]=%f", bad, exp_mem[bad]));
  endtask

  // Interprets the program on plain arrays; pushes the expected switch traffic and finish time.
  task automatic model();
    shortreal m [MS];
    shortreal vb [W];
    shortreal v;
    logic [31:0] ins;
    int pc, cyc, op, core, a, d;
    for (int i = 0; i < MS; i++) m[i] = mem0[i];
    for (int i = 0; i < W; i++) vb[i] = 0.0;
    pc = 0;
    cyc = 0;
    for (int s = 0; s < 1000; s++) begin
      ins = prog[pc];
      op = int'(ins[31:28]);
      core = int'(ins[27:24]) % N;
      a = int'(ins[15:0]) % MS;
      cyc++;
      if (op == 0) break;
      case (op)
        1: for (int i = 0; i < W; i++) vb[i] = m[(a + i) % MS];
        2: for (int i = 0; i < W; i++) m[(a + i) % MS] = vb[i];
        3: begin
          d = s_fix >= 0 ? s_fix : $urandom_range(0, 3);
          send_core_q.push_back(core);
          for (int i = 0; i < W; i++) send_data_q.push_back(vb[i]);
          send_dly_q.push_back(d);
          send_len_q.push_back(d + 1);
          cyc += d + 1;
        end
        4: begin
          d = r_fix >= 0 ? r_fix : $urandom_range(0, 3);
          recv_core_q.push_back(core);
          recv_dly_q.push_back(d);
          for (int i = 0; i < W; i++) begin
            v = recv_fix >= 0.0 ? recv_fix : $urandom_range(0, 16) + 0.25;
            recv_vec_q.push_back(v);
            vb[i] = v;
          end
          cyc += d + 1;
        end
        5: for (int i = 0; i < W; i++) vb[i] = vb[i] + m[(a + i) % MS];
`ifdef MAT_CORE_VMUL_EN
        6: for (int i = 0; i < W; i++) vb[i] = vb[i] * m[(a + i) % MS];
`endif
        default: ;
      endcase
      pc = (pc + 1) % MS;
    end
    done_q.push_back(cyc);
    for (int i = 0; i < MS; i++) exp_mem[i] = m[i];
  endtask

  task automatic load_prog();
    @(negedge clock);
    reset = 1'b0;
    send_core_q.delete(); send_dly_q.delete(); send_len_q.delete(); send_data_q.delete();
    recv_core_q.delete(); recv_dly_q.delete(); recv_vec_q.delete(); done_q.delete();
    done_checked = 0;
    @(negedge clock);
    for (int i = 0; i < MS; i++) begin
      dut.inst_mem.inst_mem[i] <= prog[i];
      dut.data_mem.data_mem[i] <= mem0[i];
    end
    model();
    @(negedge clock);
    #1;
    check("reset_state", !done && !send_ready && !recv_request && dut.pc == 0 && send_idx == 0 && recv_idx == 0,
          $sformatf("done=%b sr=%b rq=%b pc=%0d", done, send_ready, recv_request, dut.pc), "done=0 sr=0 rq=0 pc=0");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_prog(input string name);
    int t;
    load_prog();
    t = 0;
    while (!done_checked && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (!done_checked) check({name, "_timeout"}, 1'b0, "no done", "done");
    repeat (4) @(negedge clock);
    mem_check({name, "_mem_after_halt"});
    check({name, "_drained"}, send_core_q.size() == 0 && recv_core_q.size() == 0,
          $sformatf("%0d sends %0d recvs left", send_core_q.size(), recv_core_q.size()), "0 left");
  endtask

  task automatic clear_prog();
    for (int i = 0; i < MS; i++) begin
      prog[i] = 32'h0;
      mem0[i] = 0.0;
    end
    s_fix = -1;
    r_fix = -1;
    recv_fix = -1.0;
  endtask

  // Switch model: answers waits after the scheduled delay, and toggles the handshake inputs randomly when nothing is pending.
  initial begin
    int s_cnt, r_cnt;
    s_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < W; i++) recv_data[i] = 0.0;
    forever begin
      @(negedge clock);
      send_ok = 1'b0;
      recv_ready = 1'b0;
      if (!send_ready) begin
        s_cnt = 0;
        send_ok = 1'($urandom_range(0, 1));
      end else if (send_dly_q.size() > 0) begin
        if (s_cnt == send_dly_q[0]) begin
          send_ok = 1'b1;
          s_cnt = 0;
          void'(send_dly_q.pop_front());
        end else s_cnt++;
      end
      if (!recv_request) begin
        r_cnt = 0;
        recv_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) recv_data[i] = $urandom_range(0, 50);
      end else if (recv_dly_q.size() > 0 && recv_vec_q.size() >= W) begin
        if (r_cnt == recv_dly_q[0]) begin
          recv_ready = 1'b1;
          r_cnt = 0;
          void'(recv_dly_q.pop_front());
          for (int i = 0; i < W; i++) recv_data[i] = recv_vec_q.pop_front();
        end else r_cnt++;
      end
    end
  end

  // Monitor: compares every presented output against the queued expectations.
  initial begin
    int s_run;
    bit ok;
    s_run = 0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) s_run = 0;
      else begin
        if (send_ready) begin
          s_run++;
          if (send_core_q.size() == 0) check("send_unexpected", 1'b0, "send_ready=1", "no send");
          else begin
            ok = send_idx == CAW'(send_core_q[0]);
            for (int i = 0; i < W; i++) ok &= send_data[i] == send_data_q[i];
            check("send_payload", ok, $sformatf("core %0d d0 %f d15 %f", send_idx, send_data[0], send_data[W-1]),
                  $sformatf("core %0d d0 %f d15 %f", send_core_q[0], send_data_q[0], send_data_q[W-1]));
            if (send_ok) begin
              void'(send_core_q.pop_front());
              for (int i = 0; i < W; i++) void'(send_data_q.pop_front());
            end
          end
        end else if (s_run > 0) begin
          check("send_ready_len", send_len_q.size() > 0 && s_run == send_len_q[0], $sformatf("%0d cycles", s_run),
                $sformatf("%0d cycles", send_len_q.size() > 0 ? send_len_q[0] : 0));
          if (send_len_q.size() > 0) void'(send_len_q.pop_front());
          s_run = 0;
        end
        if (recv_request) begin
          if (recv_core_q.size() == 0) check("recv_unexpected", 1'b0, "recv_request=1", "no recv");
          else begin
            check("recv_core", recv_idx == CAW'(recv_core_q[0]), $sformatf("%0d", recv_idx), $sformatf("%0d", recv_core_q[0]));
            if (recv_ready) void'(recv_core_q.pop_front());
          end
        end
        ok = (send_ready || send_idx == 0) && (recv_request || recv_idx == 0);
        if (!send_ready) for (int i = 0; i < W; i++) ok &= send_data[i] == 0.0;
        check("idle_outputs", ok, $sformatf("sidx %0d ridx %0d d0 %f", send_idx, recv_idx, send_data[0]), "idle fields zero");
        if (done && !done_checked) begin
          if (done_q.size() == 0) check("done_unexpected", 1'b0, "done=1", "no done");
          else begin
            check("done_cycle", edges == done_q[0], $sformatf("%0d", edges), $sformatf("%0d", done_q[0]));
            void'(done_q.pop_front());
          end
          mem_check("mem_at_done");
          done_checked = 1;
        end
        if (done_checked) check("done_held", done == 1'b1, $sformatf("%b", done), "1");
      end
    end
  end

  initial begin
    clear_prog();
    for (int i = 0; i < 16; i++) mem0[i] = i + 1;
    prog[0] = enc(1, 0, 0);
    prog[1] = enc(2, 0, 32);
    run_prog("load_store");
    for (int i = 0; i < 16; i++) check("load_store_literal", dut.data_mem.data_mem[32 + i] == shortreal'(i + 1),
                                       $sformatf("%f", dut.data_mem.data_mem[32 + i]), $sformatf("%0d.0", i + 1));

    for (int v = 5; v <= 6; v++) begin
      clear_prog();
      for (int i = 0; i < 16; i++) begin
        mem0[i] = 2.0;
        mem0[16 + i] = 3.0;
      end
      prog[0] = enc(1, 0, 0);
      prog[1] = enc(v, 0, 16);
      prog[2] = enc(2, 0, 64);
      run_prog(v == 5 ? "vadd" : "vmul");
    end

    clear_prog();
    for (int i = 0; i < 16; i++) mem0[i] = i * 1.5;
    s_fix = 3;
    prog[0] = enc(1, 0, 0);
    prog[1] = enc(3, 2, 0);
    run_prog("send_delay3");

    clear_prog();
    r_fix = 2;
    recv_fix = 7.5;
    prog[0] = enc(4, 1, 0);
    prog[1] = enc(2, 0, 100);
    run_prog("recv_store");

    clear_prog();
    for (int i = 0; i < MS; i++) mem0[i] = i < 250 ? i : 9.0;
    prog[0] = enc(1, 0, 250);
    prog[1] = enc(2, 0, 128);
    run_prog("load_wrap");
    for (int k = 0; k < W; k++) check("wrap_vbuf", dut.vbuf[k] == (k < 6 ? 9.0 : shortreal'(k - 6)),
                                      $sformatf("vbuf[%0d]=%f", k, dut.vbuf[k]), $sformatf("%f", k < 6 ? 9.0 : shortreal'(k - 6)));

    clear_prog();
    s_fix = 1000;
    prog[0] = enc(3, 1, 0);
    load_prog();
    begin
      int t;
      t = 0;
      while (!send_ready && t < 20) begin
        @(negedge clock);
        #1;
        t++;
      end
      check("abort_send_entered", send_ready == 1'b1, $sformatf("%b", send_ready), "1");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("abort_outputs", !send_ready && !recv_request && !done && dut.pc == 0 && send_idx == 0,
            $sformatf("sr=%b rq=%b done=%b pc=%0d", send_ready, recv_request, done, dut.pc), "sr=0 rq=0 done=0 pc=0");
    end

    for (int r = 0; r < 10; r++) begin
      int len;
      clear_prog();
      for (int i = 0; i < MS; i++) mem0[i] = $urandom_range(0, 8) + 0.5;
      len = $urandom_range(4, 12);
      for (int k = 0; k < len; k++) prog[k] = enc($urandom_range(1, 9), $urandom_range(0, 15), $urandom_range(0, 65535));
      run_prog($sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
